// File: rtl/paillier_result_collector.sv
// Paillier result collector: per-core word FIFOs framed into fixed-size
// results, drained round-robin as whole packets onto one valid/ready stream.

module paillier_result_collector #(
    parameter int CH_COUNT      = 18,
    parameter int K             = 128,
    parameter int WORDS_PER_RES = 32,
    parameter int FAW           = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CH_COUNT-1:0]   in_valid,
    input  logic [CH_COUNT*K-1:0] in_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [K-1:0]          m_data,
    output logic                  m_last,
    output logic [((CH_COUNT > 1) ? $clog2(CH_COUNT) : 1)-1:0] m_chan,
    output logic [CH_COUNT-1:0]   ovf,
    input  logic                  clr_ovf,
    output logic                  busy
);

    localparam int DEPTH = 2 ** FAW;
    localparam int PW    = FAW + 1;
    localparam int RCW   = FAW + 2;
    localparam int CW    = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1;
    localparam int WCW   = (WORDS_PER_RES > 1) ? $clog2(WORDS_PER_RES) : 1;

    generate
        if (DEPTH < WORDS_PER_RES) begin : g_depth_chk
            $error("FIFO depth 2**FAW must hold at least one full result");
        end
    endgenerate

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [K-1:0]     mem     [CH_COUNT][DEPTH];
    logic [PW-1:0]    wr_ptr  [CH_COUNT];
    logic [PW-1:0]    rd_ptr  [CH_COUNT];
    logic [WCW-1:0]   wcnt    [CH_COUNT];
    logic [RCW-1:0]   res_cnt [CH_COUNT];

    logic [CH_COUNT-1:0] full;
    logic [CH_COUNT-1:0] empty;
    logic [CH_COUNT-1:0] push;
    logic [CH_COUNT-1:0] pop;
    logic [CH_COUNT-1:0] drop;
    logic [CH_COUNT-1:0] res_done;
    logic [CH_COUNT-1:0] res_take;
    logic [CH_COUNT-1:0] pending;

    logic [CW-1:0]  grant;
    logic [CW-1:0]  rr;
    logic [CW-1:0]  pick;
    logic           found;
    logic [WCW-1:0] beat;
    logic           hs;
    logic           last_beat;

    assign m_valid   = (state == STREAM);
    assign hs        = m_valid & m_ready;
    assign last_beat = (beat == WCW'(WORDS_PER_RES - 1));
    assign m_last    = m_valid & last_beat;
    assign m_chan    = grant;
    assign busy      = (|(~empty)) | m_valid;

    // Per-channel FIFO status; a pop on a full FIFO frees room for a push.
    always_comb begin
        full     = '0;
        empty    = '0;
        push     = '0;
        pop      = '0;
        drop     = '0;
        res_done = '0;
        res_take = '0;
        pending  = '0;
        for (int c = 0; c < CH_COUNT; c++) begin
            full[c]     = ((wr_ptr[c] - rd_ptr[c]) == PW'(DEPTH));
            empty[c]    = (wr_ptr[c] == rd_ptr[c]);
            pop[c]      = hs & (grant == CW'(c)) & ~empty[c];
            push[c]     = in_valid[c] & (~full[c] | pop[c]);
            drop[c]     = in_valid[c] & full[c] & ~pop[c];
            res_done[c] = push[c] & (wcnt[c] == WCW'(WORDS_PER_RES - 1));
            res_take[c] = hs & last_beat & (grant == CW'(c));
            pending[c]  = (res_cnt[c] != '0);
        end
    end

    // Round-robin pick: lowest ready channel at or above rr, else lowest overall.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int c = 0; c < CH_COUNT; c++) begin
            if (!found && pending[c] && (CW'(c) >= rr)) begin
                found = 1'b1;
                pick  = CW'(c);
            end
        end
        for (int c = 0; c < CH_COUNT; c++) begin
            if (!found && pending[c]) begin
                found = 1'b1;
                pick  = CW'(c);
            end
        end
    end

    // First-word-fall-through head of the granted FIFO, zero when idle.
    always_comb begin
        m_data = '0;
        if (m_valid) begin
            m_data = mem[grant][rd_ptr[grant][FAW-1:0]];
        end
    end

    // FIFO storage; contents need no reset, pointers define validity.
    always_ff @(posedge clk) begin
        for (int c = 0; c < CH_COUNT; c++) begin
            if (push[c]) begin
                mem[c][wr_ptr[c][FAW-1:0]] <= in_data[c*K +: K];
            end
        end
    end

    // FIFO pointers.
    always_ff @(posedge clk) begin
        for (int c = 0; c < CH_COUNT; c++) begin
            if (rst) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
            end else begin
                if (push[c]) begin
                    wr_ptr[c] <= wr_ptr[c] + 1'b1;
                end
                if (pop[c]) begin
                    rd_ptr[c] <= rd_ptr[c] + 1'b1;
                end
            end
        end
    end

    // Framing: word counter follows every strobe so drops keep alignment.
    always_ff @(posedge clk) begin
        for (int c = 0; c < CH_COUNT; c++) begin
            if (rst) begin
                wcnt[c]    <= '0;
                res_cnt[c] <= '0;
            end else begin
                if (in_valid[c]) begin
                    if (wcnt[c] == WCW'(WORDS_PER_RES - 1)) begin
                        wcnt[c] <= '0;
                    end else begin
                        wcnt[c] <= wcnt[c] + 1'b1;
                    end
                end
                if (res_done[c] && !res_take[c]) begin
                    res_cnt[c] <= res_cnt[c] + 1'b1;
                end else if (!res_done[c] && res_take[c]) begin
                    res_cnt[c] <= res_cnt[c] - 1'b1;
                end
            end
        end
    end

    // Sticky overflow; a new drop wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= '0;
        end else begin
            ovf <= (ovf & ~{CH_COUNT{clr_ovf}}) | drop;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: start on any counted result, end on last beat.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (hs && last_beat) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant, beat counter and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant <= '0;
            rr    <= '0;
            beat  <= '0;
        end else if (state == IDLE && found) begin
            grant <= pick;
            beat  <= '0;
        end else if (hs) begin
            if (last_beat) begin
                beat <= '0;
                rr   <= (grant == CW'(CH_COUNT - 1)) ? '0 : grant + 1'b1;
            end else begin
                beat <= beat + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_paillier_result_collector.sv
// Bench for paillier_result_collector: directed cases plus random traffic,
// checked by a FIFO/round-robin reference model and a negedge monitor.

module tb_paillier_result_collector;

    localparam int CH    = 4;
    localparam int K     = 128;
    localparam int W     = 4;
    localparam int FAW   = 3;
    localparam int DEPTH = 8;
    localparam int MEMN  = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] in_valid = '0;
    logic [CH*K-1:0] in_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [K-1:0]  m_data;
    logic          m_last;
    logic [1:0]    m_chan;
    logic [CH-1:0] ovf;
    logic          clr_ovf = 1'b0;
    logic          busy;

    paillier_result_collector #(
        .CH_COUNT(CH),
        .K(K),
        .WORDS_PER_RES(W),
        .FAW(FAW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_data(in_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
        .m_last(m_last),
        .m_chan(m_chan),
        .ovf(ovf),
        .clr_ovf(clr_ovf),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [K-1:0] exp_mem [CH][MEMN];
    int wr_cnt [CH];
    int rd_cnt [CH];
    int completed [CH];
    int drained [CH];
    int wc [CH];
    logic [CH-1:0] exp_ovf = '0;

    int pkt_chans [$];
    int rr_m = 0;
    int cur_chan = 0;
    int beat_m = 0;
    int cand = 0;
    bit in_pkt = 1'b0;
    bit expect_start = 1'b0;

    function automatic void chk(input string nm, input logic [K-1:0] act,
                                input logic [K-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endfunction

    function automatic logic [K-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int occ(input int c);
        return wr_cnt[c] - rd_cnt[c];
    endfunction

    initial begin
        for (int c = 0; c < CH; c++) begin
            wr_cnt[c] = 0;
            rd_cnt[c] = 0;
            completed[c] = 0;
            drained[c] = 0;
            wc[c] = 0;
        end
    end

    // Reference model: FIFO of depth 8 per channel, framing, overflow flags.
    initial forever begin : model
        logic [CH-1:0] drop_v;
        @(posedge clk);
        drop_v = '0;
        if (rst) begin
            for (int c = 0; c < CH; c++) wc[c] = 0;
            exp_ovf = '0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (in_valid[c]) begin
                    if (occ(c) < DEPTH) begin
                        exp_mem[c][wr_cnt[c] % MEMN] = in_data[c*K +: K];
                        wr_cnt[c]++;
                        if (wc[c] == W - 1) completed[c]++;
                    end else begin
                        drop_v[c] = 1'b1;
                    end
                    wc[c] = (wc[c] + 1) % W;
                end
            end
            exp_ovf = (exp_ovf & ~{CH{clr_ovf}}) | drop_v;
        end
    end

    // Monitor: checks every output cycle against the model's expectations.
    initial forever begin : monitor
        bit fnd;
        @(negedge clk);
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                rd_cnt[c] = wr_cnt[c];
                drained[c] = completed[c];
            end
            in_pkt = 1'b0;
            expect_start = 1'b0;
            beat_m = 0;
            rr_m = 0;
        end else begin
            chk("ovf", K'(ovf), K'(exp_ovf));
            if (expect_start) begin
                chk("start_valid", K'(m_valid), K'(1));
                chk("start_chan", K'(m_chan), K'(cand));
                cur_chan = cand;
                in_pkt = 1'b1;
                beat_m = 0;
                expect_start = 1'b0;
                pkt_chans.push_back(cand);
            end else if (m_valid && !in_pkt) begin
                chk("spurious_valid", K'(m_valid), K'(0));
            end
            if (in_pkt) begin
                if (!m_valid) begin
                    chk("valid_mid_pkt", K'(m_valid), K'(1));
                    in_pkt = 1'b0;
                end else begin
                    chk("chan", K'(m_chan), K'(cur_chan));
                    chk("last", K'(m_last), K'(beat_m == W - 1));
                    if (occ(cur_chan) > 0) begin
                        chk("data", m_data,
                            exp_mem[cur_chan][rd_cnt[cur_chan] % MEMN]);
                    end
                    if (m_ready) begin
                        if (occ(cur_chan) > 0) rd_cnt[cur_chan]++;
                        if (beat_m == W - 1) begin
                            drained[cur_chan]++;
                            rr_m = (cur_chan + 1) % CH;
                            in_pkt = 1'b0;
                            beat_m = 0;
                        end else begin
                            beat_m++;
                        end
                    end
                end
            end
            if (!m_valid) begin
                fnd = 1'b0;
                for (int i = 0; i < CH; i++) begin
                    int c2;
                    c2 = (rr_m + i) % CH;
                    if (!fnd && (completed[c2] - drained[c2] > 0)) begin
                        fnd = 1'b1;
                        cand = c2;
                    end
                end
                expect_start = fnd;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = '0;
        clr_ovf = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        bit pend;
        bit any_occ;
        n = 0;
        pend = 1'b1;
        while (pend && n < 2000) begin
            cyc();
            n++;
            pend = m_valid || expect_start || in_pkt;
            for (int c = 0; c < CH; c++) begin
                if (completed[c] - drained[c] > 0) pend = 1'b1;
            end
        end
        if (pend) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: still active after %0d cycles", nm, n);
        end
        any_occ = 1'b0;
        for (int c = 0; c < CH; c++) begin
            if (occ(c) > 0) any_occ = 1'b1;
        end
        chk({nm, "_busy"}, K'(busy), K'(any_occ));
    endtask

    task automatic send(input logic [CH-1:0] mask);
        for (int c = 0; c < CH; c++) in_data[c*K +: K] = rnd_word();
        in_valid = mask;
        cyc();
    endtask

    initial begin
        int base;
        int n;

        // T1: reset state then one packet from channel 1
        repeat (3) cyc();
        chk("t1_rst_valid", K'(m_valid), K'(0));
        chk("t1_rst_ovf", K'(ovf), K'(0));
        chk("t1_rst_busy", K'(busy), K'(0));
        chk("t1_rst_data", m_data, K'(0));
        chk("t1_rst_last", K'(m_last), K'(0));
        chk("t1_rst_chan", K'(m_chan), K'(0));
        rst = 1'b0;
        m_ready = 1'b1;
        base = pkt_chans.size();
        for (int i = 0; i < 4; i++) begin
            in_data[K +: K] = K'(32'hA0 + i);
            in_valid = 4'b0010;
            cyc();
        end
        in_valid = '0;
        wait_idle("t1");
        chk("t1_pkts", K'(pkt_chans.size()), K'(base + 1));
        chk("t1_chan", K'(pkt_chans[base]), K'(1));
        chk("t1_ovf", K'(ovf), K'(0));

        // T2: round-robin order
        do_reset();
        m_ready = 1'b1;
        base = pkt_chans.size();
        repeat (4) send(4'b1101);
        in_valid = '0;
        wait_idle("t2a");
        chk("t2a_pkts", K'(pkt_chans.size()), K'(base + 3));
        chk("t2a_p0", K'(pkt_chans[base]), K'(0));
        chk("t2a_p1", K'(pkt_chans[base + 1]), K'(2));
        chk("t2a_p2", K'(pkt_chans[base + 2]), K'(3));
        base = pkt_chans.size();
        repeat (4) send(4'b1001);
        in_valid = '0;
        wait_idle("t2b");
        chk("t2b_pkts", K'(pkt_chans.size()), K'(base + 2));
        chk("t2b_p0", K'(pkt_chans[base]), K'(0));
        chk("t2b_p1", K'(pkt_chans[base + 1]), K'(3));

        // T3: backpressure pattern 1,0,0 repeating
        do_reset();
        base = pkt_chans.size();
        for (int i = 0; i < 40; i++) begin
            m_ready = (i % 3 == 0);
            if (i < 4) send(4'b0010);
            else send(4'b0000);
        end
        m_ready = 1'b1;
        in_valid = '0;
        wait_idle("t3");
        chk("t3_pkts", K'(pkt_chans.size()), K'(base + 1));
        chk("t3_chan", K'(pkt_chans[base]), K'(1));

        // T4: partial result does not start a packet
        do_reset();
        m_ready = 1'b1;
        repeat (3) send(4'b0100);
        in_valid = '0;
        repeat (4) cyc();
        chk("t4_partial_valid", K'(m_valid), K'(0));
        chk("t4_partial_busy", K'(busy), K'(1));
        send(4'b0100);
        in_valid = '0;
        chk("t4_valid_after1", K'(m_valid), K'(0));
        cyc();
        chk("t4_valid_after2", K'(m_valid), K'(1));
        chk("t4_chan", K'(m_chan), K'(2));
        wait_idle("t4");

        // T5: overflow and clear priority
        do_reset();
        m_ready = 1'b0;
        base = pkt_chans.size();
        repeat (8) send(4'b0010);
        chk("t5_ovf_full", K'(ovf), K'(0));
        send(4'b0010);
        chk("t5_ovf_set", K'(ovf), K'(4'b0010));
        clr_ovf = 1'b1;
        send(4'b0010);
        chk("t5_ovf_clr_drop", K'(ovf), K'(4'b0010));
        in_valid = '0;
        cyc();
        clr_ovf = 1'b0;
        chk("t5_ovf_clr", K'(ovf), K'(0));
        m_ready = 1'b1;
        wait_idle("t5");
        chk("t5_pkts", K'(pkt_chans.size()), K'(base + 2));

        // T6: reset in the middle of a packet
        do_reset();
        m_ready = 1'b1;
        repeat (4) send(4'b0001);
        in_valid = '0;
        n = 0;
        while (!m_valid && n < 20) begin
            cyc();
            n++;
        end
        if (!m_valid) begin
            total++;
            bad++;
            $display("FAIL t6_start_timeout: m_valid=0 after %0d cycles", n);
        end
        cyc();
        rst = 1'b1;
        cyc();
        chk("t6_rst_valid", K'(m_valid), K'(0));
        chk("t6_rst_busy", K'(busy), K'(0));
        rst = 1'b0;
        base = pkt_chans.size();
        repeat (4) send(4'b0001);
        in_valid = '0;
        wait_idle("t6");
        chk("t6_pkts", K'(pkt_chans.size()), K'(base + 1));
        chk("t6_chan", K'(pkt_chans[base]), K'(0));

        // T7: random traffic, stalls, drops and clears
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic [CH-1:0] mask;
            for (int c = 0; c < CH; c++) mask[c] = ($urandom_range(0, 99) < 25);
            m_ready = ($urandom_range(0, 99) < 70);
            clr_ovf = ($urandom_range(0, 99) < 5);
            send(mask);
        end
        in_valid = '0;
        clr_ovf = 1'b0;
        m_ready = 1'b1;
        wait_idle("t7");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
